memory_stage_lsu: RTL and testbench

MEMORY_STAGE_LSU -- requirements
Module: memory_stage_lsu

---
 rtl/memory_stage_lsu.sv | 213 +++++++++++++++++++++
 tb/tb_memory_stage_lsu.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage_lsu.sv
// -----------------------------------------------------------------------------
// memory_stage_lsu
//
// Load/store unit for the MEM stage of a 5-stage RISC-V pipeline. It turns a
// load or store in MEM into a single request on a simple ack-terminated data
// bus and holds the pipeline until the access finishes. When an access
// completes it returns the aligned, extended load result. Misaligned accesses
// are flagged and never reach the bus. A bounded wait turns a missing ack into
// a one-cycle bus error.
//
// Every access runs IDLE -> WAIT -> DONE. IDLE captures the instruction and
// stalls combinationally. WAIT holds the request until ack or timeout. DONE
// releases the stall for one cycle so that the held instruction can advance
// without being detected again.
//
// Parameters
//   TIMEOUT_CYCLES      WAIT cycles without ack before bus error (1..255)
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_insn_vld_memory       MEM-stage instruction valid
//   i_mem_rden/i_mem_wren   instruction is a load / store
//   i_lsu_op                funct3 (B, H, W, BU, HU)
//   i_alu_pc4_data_memory   effective address
//   i_rs2_data_memory       store data
//   o_dmem_*                bus request, direction, word address, data, lanes
//   i_dmem_ack/i_dmem_rdata one-cycle completion and read word
//   o_ld_data               registered load result for writeback
//   o_stall                 hold IF..EX/MEM and the MEM/WB input
//   o_misalign              current access is misaligned (suppressed)
//   o_bus_err               one-cycle pulse, access timed out
// -----------------------------------------------------------------------------
module memory_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_insn_vld_memory,
    input  logic        i_mem_rden,
    input  logic        i_mem_wren,
    input  logic [2:0]  i_lsu_op,
    input  logic [31:0] i_alu_pc4_data_memory,
    input  logic [31:0] i_rs2_data_memory,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_bmask,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic [31:0] o_ld_data,
    output logic        o_stall,
    output logic        o_misalign,
    output logic        o_bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  op_q, op_d;
    logic        rden_q, rden_d;
    logic        wren_q, wren_d;
    logic [31:0] sdata_q, sdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic        bus_err_q, bus_err_d;

    logic        mem_op_w;
    logic        mis_w;
    logic        acc_w;

    // op[1:0] encodes size: 00 byte, 01 half, 1x word. op[2] selects unsigned.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        return ((op[1:0] == 2'b01) && off[0]) || (op[1] && (off != 2'b00));
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] op, input logic [1:0] off);
        logic [3:0] m;
        case (op[1:0])
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Replicating the store data across lanes lets bmask alone pick the bytes.
    function automatic logic [31:0] store_lanes(input logic [2:0] op, input logic [31:0] data);
        logic [31:0] w;
        case (op[1:0])
            2'b00:   w = {4{data[7:0]}};
            2'b01:   w = {2{data[15:0]}};
            default: w = data;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {off, 3'b000};
        case (op)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b100:  r = {24'd0, sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b101:  r = {16'd0, sh[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

    assign mem_op_w   = i_insn_vld_memory & (i_mem_rden | i_mem_wren);
    assign mis_w      = is_misaligned(i_lsu_op, i_alu_pc4_data_memory[1:0]);
    assign acc_w      = mem_op_w & ~mis_w;
    assign o_misalign = mem_op_w & mis_w;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        op_d       = op_q;
        rden_d     = rden_q;
        wren_d     = wren_q;
        sdata_d    = sdata_q;
        cnt_d      = cnt_q;
        ld_data_d  = ld_data_q;
        bus_err_d  = 1'b0;
        o_stall    = 1'b0;
        o_dmem_req = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Stall in the same cycle so the pipeline holds the instruction
                // while it is captured.
                o_stall = acc_w;
                if (acc_w) begin
                    addr_d  = i_alu_pc4_data_memory;
                    op_d    = i_lsu_op;
                    rden_d  = i_mem_rden;
                    wren_d  = i_mem_wren;
                    sdata_d = i_rs2_data_memory;
                    cnt_d   = 8'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                o_dmem_req = 1'b1;
                o_stall    = 1'b1;
                // Ack has priority over a timeout in the same cycle.
                if (i_dmem_ack) begin
                    if (rden_q) begin
                        ld_data_d = load_extract(op_q, addr_q[1:0], i_dmem_rdata);
                    end
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                // The held instruction leaves MEM at the end of this cycle, so
                // returning to IDLE without looking at acc avoids a replay.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            addr_q    <= 32'd0;
            op_q      <= 3'd0;
            rden_q    <= 1'b0;
            wren_q    <= 1'b0;
            sdata_q   <= 32'd0;
            cnt_q     <= 8'd0;
            ld_data_q <= 32'd0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            op_q      <= op_d;
            rden_q    <= rden_d;
            wren_q    <= wren_d;
            sdata_q   <= sdata_d;
            cnt_q     <= cnt_d;
            ld_data_q <= ld_data_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Bus-side fields come only from captured state, so they stay stable
    // while the request is outstanding.
    assign o_dmem_we    = wren_q;
    assign o_dmem_addr  = {addr_q[31:2], 2'b00};
    assign o_dmem_wdata = store_lanes(op_q, sdata_q);
    assign o_dmem_bmask = lane_mask(op_q, addr_q[1:0]);
    assign o_ld_data    = ld_data_q;
    assign o_bus_err    = bus_err_q;

endmodule

// File: tb/tb_memory_stage_lsu.sv
// -----------------------------------------------------------------------------
// tb_memory_stage_lsu
//
// Bench for memory_stage_lsu with TIMEOUT_CYCLES = 4. Each scenario task drives
// one or more MEM-stage accesses through a small bus driver. It compares what
// it observes with values from a reference model of the load/store rules, which
// is written with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_memory_stage_lsu;

    localparam int T = 4;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_insn_vld_memory;
    logic        i_mem_rden;
    logic        i_mem_wren;
    logic [2:0]  i_lsu_op;
    logic [31:0] i_alu_pc4_data_memory;
    logic [31:0] i_rs2_data_memory;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_bmask;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic [31:0] o_ld_data;
    logic        o_stall;
    logic        o_misalign;
    logic        o_bus_err;

    memory_stage_lsu #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk                 (i_clk),
        .i_reset               (i_reset),
        .i_insn_vld_memory     (i_insn_vld_memory),
        .i_mem_rden            (i_mem_rden),
        .i_mem_wren            (i_mem_wren),
        .i_lsu_op              (i_lsu_op),
        .i_alu_pc4_data_memory (i_alu_pc4_data_memory),
        .i_rs2_data_memory     (i_rs2_data_memory),
        .o_dmem_req            (o_dmem_req),
        .o_dmem_we             (o_dmem_we),
        .o_dmem_addr           (o_dmem_addr),
        .o_dmem_wdata          (o_dmem_wdata),
        .o_dmem_bmask          (o_dmem_bmask),
        .i_dmem_ack            (i_dmem_ack),
        .i_dmem_rdata          (i_dmem_rdata),
        .o_ld_data             (o_ld_data),
        .o_stall               (o_stall),
        .o_misalign            (o_misalign),
        .o_bus_err             (o_bus_err)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference-model state: last load value the block should be holding.
    logic [31:0] exp_ld;

    // Observations collected by the bus driver.
    int          obs_stall_cycles;
    int          obs_wait;
    logic        obs_mis_idle;
    logic        obs_we;
    logic [31:0] obs_addr;
    logic [31:0] obs_wdata;
    logic [3:0]  obs_mask;
    logic        obs_unstable;
    logic        obs_berr_early;
    logic        obs_done_stall;
    logic        obs_berr_done;
    logic [31:0] obs_ld;
    logic        obs_hung;

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] op);
        if (op[1:0] == 2'b00) return 1;
        if (op[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] ref_mask(input logic [2:0] op, input logic [31:0] addr);
        int off = int'(addr[1:0]);
        int m = ((1 << size_of(op)) - 1) << off;
        return m[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] op, input logic [31:0] rs2);
        if (size_of(op) == 1) return (rs2 & 32'hFF) * 32'h0101_0101;
        if (size_of(op) == 2) return (rs2 & 32'hFFFF) * 32'h0001_0001;
        return rs2;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        longint v;
        longint lim;
        int off = int'(addr[1:0]);
        lim = longint'(1) << (8 * size_of(op));
        v = longint'(rdata >> (8 * off)) % lim;
        if (!op[2] && size_of(op) < 4 && v >= lim / 2) v = v - lim;
        return v[31:0];
    endfunction

    // ---------------- bus driver ----------------
    // ack_wait: WAIT cycle (1-based) in which ack is given; 0 means never.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] op,
                              input logic [31:0] addr, input logic [31:0] rs2,
                              input logic [31:0] rdata, input int ack_wait);
        logic done = 1'b0;
        obs_stall_cycles = 0;
        obs_wait         = 0;
        obs_unstable     = 1'b0;
        obs_berr_early   = 1'b0;
        obs_done_stall   = 1'b1;
        obs_berr_done    = 1'b0;
        obs_ld           = 32'hx;
        @(negedge i_clk);
        i_insn_vld_memory     = 1'b1;
        i_mem_rden            = rd;
        i_mem_wren            = wr;
        i_lsu_op              = op;
        i_alu_pc4_data_memory = addr;
        i_rs2_data_memory     = rs2;
        i_dmem_ack            = 1'b0;
        #1;
        if (o_stall) obs_stall_cycles++;
        obs_mis_idle = o_misalign;
        if (o_bus_err) obs_berr_early = 1'b1;
        for (int k = 1; k <= 16 && !done; k++) begin
            @(negedge i_clk);
            // Scramble the live operands: the bus must use captured values.
            i_alu_pc4_data_memory = $urandom;
            i_rs2_data_memory     = $urandom;
            i_dmem_ack            = (k == ack_wait);
            i_dmem_rdata          = (k == ack_wait) ? rdata : $urandom;
            #1;
            if (o_dmem_req) begin
                if (o_stall) obs_stall_cycles++;
                if (o_bus_err) obs_berr_early = 1'b1;
                if (obs_wait == 0) begin
                    obs_we    = o_dmem_we;
                    obs_addr  = o_dmem_addr;
                    obs_wdata = o_dmem_wdata;
                    obs_mask  = o_dmem_bmask;
                end else if (o_dmem_we !== obs_we || o_dmem_addr !== obs_addr ||
                             o_dmem_wdata !== obs_wdata || o_dmem_bmask !== obs_mask) begin
                    obs_unstable = 1'b1;
                end
                obs_wait++;
            end else begin
                obs_done_stall = o_stall;
                obs_berr_done  = o_bus_err;
                obs_ld         = o_ld_data;
                done = 1'b1;
            end
        end
        i_dmem_ack = 1'b0;
        obs_hung = !done;
    endtask

    task automatic go_idle();
        @(negedge i_clk);
        i_insn_vld_memory = 1'b0;
        i_mem_rden        = 1'b0;
        i_mem_wren        = 1'b0;
        i_dmem_ack        = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        i_reset = 1'b1;
        i_insn_vld_memory = 1'b0; i_mem_rden = 1'b0; i_mem_wren = 1'b0;
        i_lsu_op = 3'b010; i_alu_pc4_data_memory = 32'h0; i_rs2_data_memory = 32'h0;
        i_dmem_ack = 1'b0; i_dmem_rdata = 32'h0;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        #1;
        n_checks++; if (o_dmem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", o_dmem_req); else n_pass++;
        n_checks++; if (o_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", o_stall); else n_pass++;
        n_checks++; if (o_bus_err !== 1'b0) $display("FAIL reset_buserr: got %b want 0", o_bus_err); else n_pass++;
        n_checks++; if (o_ld_data !== 32'h0) $display("FAIL reset_lddata: got %h want 0", o_ld_data); else n_pass++;
        exp_ld = 32'h0;
    endtask

    task automatic test_lw_basic();
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2);
        exp_ld = 32'hDEADBEEF;
        n_checks++; if (obs_hung) $display("FAIL lw_done: no DONE within bound"); else n_pass++;
        n_checks++; if (obs_stall_cycles != 3) $display("FAIL lw_stall_cycles: got %0d want 3", obs_stall_cycles); else n_pass++;
        n_checks++; if (obs_ld !== exp_ld) $display("FAIL lw_data: got %h want %h", obs_ld, exp_ld); else n_pass++;
        n_checks++; if (obs_addr !== 32'h100) $display("FAIL lw_addr: got %h want 00000100", obs_addr); else n_pass++;
        n_checks++; if (obs_mask !== 4'b1111) $display("FAIL lw_mask: got %b want 1111", obs_mask); else n_pass++;
        n_checks++; if (obs_we !== 1'b0) $display("FAIL lw_we: got %b want 0", obs_we); else n_pass++;
        n_checks++; if (obs_done_stall !== 1'b0) $display("FAIL lw_done_stall: got %b want 0", obs_done_stall); else n_pass++;
        n_checks++; if (obs_mis_idle !== 1'b0) $display("FAIL lw_misalign: got %b want 0", obs_mis_idle); else n_pass++;
        go_idle();
    endtask

    task automatic test_load_extend();
        logic [2:0]  ops [4]  = '{3'b000, 3'b100, 3'b101, 3'b001};
        logic [31:0] adrs [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] want [4] = '{32'hFFFFFF80, 32'h00000080, 32'h000080AA, 32'hFFFF80AA};
        logic [3:0]  msk [4]  = '{4'b1000, 4'b1000, 4'b1100, 4'b1100};
        for (int i = 0; i < 4; i++) begin
            run_access(1'b1, 1'b0, ops[i], adrs[i], 32'h0, 32'h80AABBCC, 1);
            exp_ld = ref_load(ops[i], adrs[i], 32'h80AABBCC);
            n_checks++; if (obs_ld !== want[i]) $display("FAIL ld_ext_%0d: got %h want %h", i, obs_ld, want[i]); else n_pass++;
            n_checks++; if (obs_mask !== msk[i]) $display("FAIL ld_mask_%0d: got %b want %b", i, obs_mask, msk[i]); else n_pass++;
        end
        go_idle();
    endtask

    task automatic test_store();
        run_access(1'b0, 1'b1, 3'b000, 32'h101, 32'h12345678, 32'h0, 1);
        n_checks++; if (obs_we !== 1'b1) $display("FAIL sb_we: got %b want 1", obs_we); else n_pass++;
        n_checks++; if (obs_mask !== 4'b0010) $display("FAIL sb_mask: got %b want 0010", obs_mask); else n_pass++;
        n_checks++; if (obs_wdata !== 32'h78787878) $display("FAIL sb_wdata: got %h want 78787878", obs_wdata); else n_pass++;
        n_checks++; if (obs_addr !== 32'h100) $display("FAIL sb_addr: got %h want 00000100", obs_addr); else n_pass++;
        n_checks++; if (obs_ld !== exp_ld) $display("FAIL sb_ld_hold: got %h want %h", obs_ld, exp_ld); else n_pass++;
        run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h12345678, 32'h0, 3);
        n_checks++; if (obs_mask !== 4'b1100) $display("FAIL sh_mask: got %b want 1100", obs_mask); else n_pass++;
        n_checks++; if (obs_wdata !== 32'h56785678) $display("FAIL sh_wdata: got %h want 56785678", obs_wdata); else n_pass++;
        n_checks++; if (obs_unstable) $display("FAIL sh_stable: bus fields changed during WAIT"); else n_pass++;
        go_idle();
    endtask

    task automatic test_misalign();
        @(negedge i_clk);
        i_insn_vld_memory = 1'b1; i_mem_rden = 1'b1; i_mem_wren = 1'b0;
        i_lsu_op = 3'b010; i_alu_pc4_data_memory = 32'h102;
        #1;
        n_checks++; if (o_misalign !== 1'b1) $display("FAIL mis_flag: got %b want 1", o_misalign); else n_pass++;
        n_checks++; if (o_stall !== 1'b0) $display("FAIL mis_stall: got %b want 0", o_stall); else n_pass++;
        @(negedge i_clk);
        #1;
        n_checks++; if (o_dmem_req !== 1'b0) $display("FAIL mis_req: got %b want 0", o_dmem_req); else n_pass++;
        n_checks++; if (o_stall !== 1'b0) $display("FAIL mis_stays_idle: stall %b want 0", o_stall); else n_pass++;
        // Bubble with rden set must not start an access.
        @(negedge i_clk);
        i_insn_vld_memory = 1'b0; i_alu_pc4_data_memory = 32'h100;
        #1;
        n_checks++; if (o_stall !== 1'b0 || o_misalign !== 1'b0) $display("FAIL bubble_comb: stall %b mis %b want 0 0", o_stall, o_misalign); else n_pass++;
        @(negedge i_clk);
        #1;
        n_checks++; if (o_dmem_req !== 1'b0) $display("FAIL bubble_req: got %b want 0", o_dmem_req); else n_pass++;
        go_idle();
    endtask

    task automatic test_timeout();
        run_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h0BADF00D, 0);
        n_checks++; if (obs_wait != T) $display("FAIL to_wait_cycles: got %0d want %0d", obs_wait, T); else n_pass++;
        n_checks++; if (obs_berr_done !== 1'b1) $display("FAIL to_buserr: got %b want 1", obs_berr_done); else n_pass++;
        n_checks++; if (obs_berr_early !== 1'b0) $display("FAIL to_buserr_early: got %b want 0", obs_berr_early); else n_pass++;
        n_checks++; if (obs_ld !== exp_ld) $display("FAIL to_ld_hold: got %h want %h", obs_ld, exp_ld); else n_pass++;
        go_idle();
        #1;
        n_checks++; if (o_bus_err !== 1'b0) $display("FAIL to_pulse_width: got %b want 0", o_bus_err); else n_pass++;
        run_access(1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 32'hCAFEF00D, T);
        exp_ld = 32'hCAFEF00D;
        n_checks++; if (obs_berr_done !== 1'b0) $display("FAIL ack_wins_buserr: got %b want 0", obs_berr_done); else n_pass++;
        n_checks++; if (obs_ld !== exp_ld) $display("FAIL ack_wins_data: got %h want %h", obs_ld, exp_ld); else n_pass++;
        go_idle();
    endtask

    task automatic test_stray_ack();
        @(negedge i_clk);
        i_dmem_ack = 1'b1; i_dmem_rdata = 32'h55555555;
        @(negedge i_clk);
        i_dmem_ack = 1'b0;
        #1;
        n_checks++; if (o_ld_data !== exp_ld) $display("FAIL stray_ack_ld: got %h want %h", o_ld_data, exp_ld); else n_pass++;
        n_checks++; if (o_dmem_req !== 1'b0) $display("FAIL stray_ack_req: got %b want 0", o_dmem_req); else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        @(negedge i_clk);
        i_insn_vld_memory = 1'b1; i_mem_rden = 1'b1; i_mem_wren = 1'b0;
        i_lsu_op = 3'b010; i_alu_pc4_data_memory = 32'h200;
        @(negedge i_clk);
        #1;
        n_checks++; if (o_dmem_req !== 1'b1) $display("FAIL rst_wait_req: got %b want 1", o_dmem_req); else n_pass++;
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0; i_insn_vld_memory = 1'b0; i_mem_rden = 1'b0;
        i_dmem_ack = 1'b1; i_dmem_rdata = 32'h11111111;
        #1;
        exp_ld = 32'h0;
        n_checks++; if (o_dmem_req !== 1'b0) $display("FAIL rst_wait_req_drop: got %b want 0", o_dmem_req); else n_pass++;
        n_checks++; if (o_ld_data !== 32'h0) $display("FAIL rst_wait_ld: got %h want 0", o_ld_data); else n_pass++;
        @(negedge i_clk);
        i_dmem_ack = 1'b0;
        #1;
        n_checks++; if (o_ld_data !== 32'h0) $display("FAIL rst_ack_ignored: got %h want 0", o_ld_data); else n_pass++;
        n_checks++; if (o_stall !== 1'b0 || o_bus_err !== 1'b0) $display("FAIL rst_after_idle: stall %b berr %b want 0 0", o_stall, o_bus_err); else n_pass++;
    endtask

    task automatic test_back_to_back();
        run_access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h01020304, 1);
        exp_ld = 32'h01020304;
        n_checks++; if (obs_ld !== exp_ld) $display("FAIL b2b_first: got %h want %h", obs_ld, exp_ld); else n_pass++;
        run_access(1'b1, 1'b0, 3'b010, 32'h304, 32'h0, 32'hA0B0C0D0, 1);
        exp_ld = 32'hA0B0C0D0;
        n_checks++; if (obs_stall_cycles != 2) $display("FAIL b2b_stall: got %0d want 2", obs_stall_cycles); else n_pass++;
        n_checks++; if (obs_addr !== 32'h304) $display("FAIL b2b_addr: got %h want 00000304", obs_addr); else n_pass++;
        n_checks++; if (obs_ld !== exp_ld) $display("FAIL b2b_second: got %h want %h", obs_ld, exp_ld); else n_pass++;
        go_idle();
    endtask

    task automatic test_random();
        logic [2:0] ld_ops [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < 40; i++) begin
            logic        st   = ($urandom_range(0, 2) == 0);
            logic [2:0]  op   = st ? ld_ops[$urandom_range(0, 2)] : ld_ops[$urandom_range(0, 4)];
            logic [31:0] addr = $urandom & ~(size_of(op) - 1);
            logic [31:0] rs2  = $urandom;
            logic [31:0] rd   = $urandom;
            int          aw   = $urandom_range(0, T + 1);
            logic        acked = (aw >= 1 && aw <= T);
            int          exp_wait = acked ? aw : T;
            run_access(!st, st, op, addr, rs2, rd, aw);
            if (!st && acked) exp_ld = ref_load(op, addr, rd);
            n_checks++;
            if (obs_hung || obs_stall_cycles != exp_wait + 1 || obs_unstable)
                $display("FAIL rnd_flow_%0d: stall %0d unstable %b hung %b want stall %0d", i, obs_stall_cycles, obs_unstable, obs_hung, exp_wait + 1);
            else n_pass++;
            n_checks++;
            if (obs_we !== st || obs_addr !== (addr & 32'hFFFF_FFFC) || obs_mask !== ref_mask(op, addr))
                $display("FAIL rnd_bus_%0d: we %b addr %h mask %b want %b %h %b", i, obs_we, obs_addr, obs_mask, st, addr & 32'hFFFF_FFFC, ref_mask(op, addr));
            else n_pass++;
            if (st) begin
                n_checks++;
                if (obs_wdata !== ref_wdata(op, rs2)) $display("FAIL rnd_wdata_%0d: got %h want %h", i, obs_wdata, ref_wdata(op, rs2));
                else n_pass++;
            end
            n_checks++;
            if (obs_berr_done !== !acked || obs_berr_early !== 1'b0)
                $display("FAIL rnd_buserr_%0d: done %b early %b want %b 0", i, obs_berr_done, obs_berr_early, !acked);
            else n_pass++;
            n_checks++;
            if (obs_ld !== exp_ld) $display("FAIL rnd_ld_%0d: got %h want %h", i, obs_ld, exp_ld);
            else n_pass++;
            if ($urandom_range(0, 1) == 0) go_idle();
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_lw_basic();
        test_load_extend();
        test_store();
        test_misalign();
        test_timeout();
        test_stray_ack();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
